// File: rtl/ls_exec_unit.sv
// Load/store execution stage: performs one memory op at a time, byte-serially over an
// arbitrated 8-bit port, and returns extended load results on the LS CDB.
module ls_exec_unit #(
  parameter int ROB_W = 4,
  parameter int OP_W  = 6,
  parameter logic [OP_W-1:0] OP_LB  = 1,
  parameter logic [OP_W-1:0] OP_LH  = 2,
  parameter logic [OP_W-1:0] OP_LW  = 3,
  parameter logic [OP_W-1:0] OP_LBU = 4,
  parameter logic [OP_W-1:0] OP_LHU = 5,
  parameter logic [OP_W-1:0] OP_SB  = 6,
  parameter logic [OP_W-1:0] OP_SH  = 7,
  parameter logic [OP_W-1:0] OP_SW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_from_lsb,
  input  logic [OP_W-1:0]  openum_from_lsb,
  input  logic [31:0]      mem_addr_from_lsb,
  input  logic [31:0]      store_value_from_lsb,
  input  logic [ROB_W-1:0] rob_id_from_lsb,
  output logic             busy_to_lsb,
  input  logic             jump_flag_from_rob,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [31:0]      mem_a,
  output logic [7:0]       mem_dout,
  input  logic [7:0]       mem_din,
  input  logic             mem_grant,
  output logic             valid_to_cdb,
  output logic [ROB_W-1:0] rob_id_to_cdb,
  output logic [31:0]      result_to_cdb
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [OP_W-1:0]  op_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      data_reg;
  logic [ROB_W-1:0] rob_reg;
  logic [2:0]       size_reg;
  logic             store_reg;
  logic [1:0]       issue_cnt_reg;
  logic [1:0]       cap_cnt_reg;
  logic             pend_reg;
  logic [31:0]      buf_w;

  logic [2:0] req_size;
  logic       req_store;
  logic       accept;
  logic       issue_last;
  logic       cap_last;
  logic       flush_load;

  // Unknown op codes decode to size 0 and are never accepted.
  always_comb begin
    req_size  = 3'd0;
    req_store = 1'b0;
    case (openum_from_lsb)
      OP_LB, OP_LBU: req_size = 3'd1;
      OP_LH, OP_LHU: req_size = 3'd2;
      OP_LW:         req_size = 3'd4;
      OP_SB: begin req_size = 3'd1; req_store = 1'b1; end
      OP_SH: begin req_size = 3'd2; req_store = 1'b1; end
      OP_SW: begin req_size = 3'd4; req_store = 1'b1; end
      default: req_size = 3'd0;
    endcase
  end

  // Stores are already committed, so a coincident flush only drops loads.
  assign accept     = (state_reg == IDLE) && ena_from_lsb && (req_size != 3'd0) &&
                      (req_store || !jump_flag_from_rob);
  assign issue_last = mem_grant && ({1'b0, issue_cnt_reg} == size_reg - 3'd1);
  assign cap_last   = pend_reg && ({1'b0, cap_cnt_reg} == size_reg - 3'd1);
  assign flush_load = jump_flag_from_rob && !store_reg;
  assign busy_to_lsb = (state_reg != IDLE) | ena_from_lsb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: begin
        if (flush_load)      state_next = IDLE;
        else if (issue_last) state_next = store_reg ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (flush_load)    state_next = IDLE;
        else if (cap_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg        <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      rob_reg       <= '0;
      size_reg      <= '0;
      store_reg     <= 1'b0;
      issue_cnt_reg <= '0;
      cap_cnt_reg   <= '0;
      pend_reg      <= 1'b0;
    end else if (accept) begin
      op_reg        <= openum_from_lsb;
      addr_reg      <= mem_addr_from_lsb;
      data_reg      <= store_value_from_lsb;
      rob_reg       <= rob_id_from_lsb;
      size_reg      <= req_size;
      store_reg     <= req_store;
      issue_cnt_reg <= '0;
      cap_cnt_reg   <= '0;
      pend_reg      <= 1'b0;
    end else begin
      if (state_reg == ISSUE && mem_grant) issue_cnt_reg <= issue_cnt_reg + 2'd1;
      // Read data arrives the cycle after its grant, whatever the grant is doing then.
      pend_reg <= (state_reg == ISSUE) && !store_reg && mem_grant;
      if (pend_reg) cap_cnt_reg <= cap_cnt_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [7:0] byte_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    byte_reg <= '0;
        else if (pend_reg && cap_cnt_reg == 2'(gi))  byte_reg <= mem_din;
      end
      assign buf_w[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  always_comb begin
    mem_req       = 1'b0;
    mem_wr        = 1'b0;
    mem_a         = '0;
    mem_dout      = '0;
    valid_to_cdb  = 1'b0;
    rob_id_to_cdb = '0;
    result_to_cdb = '0;
    case (state_reg)
      ISSUE: begin
        mem_req  = 1'b1;
        mem_wr   = store_reg;
        mem_a    = addr_reg + {30'd0, issue_cnt_reg};
        mem_dout = store_reg ? data_reg[{issue_cnt_reg, 3'b000} +: 8] : 8'h00;
      end
      DONE: begin
        if (!jump_flag_from_rob) begin
          valid_to_cdb  = 1'b1;
          rob_id_to_cdb = rob_reg;
          case (op_reg)
            OP_LB:   result_to_cdb = {{24{buf_w[7]}}, buf_w[7:0]};
            OP_LH:   result_to_cdb = {{16{buf_w[15]}}, buf_w[15:0]};
            OP_LBU:  result_to_cdb = {24'd0, buf_w[7:0]};
            OP_LHU:  result_to_cdb = {16'd0, buf_w[15:0]};
            default: result_to_cdb = buf_w;
          endcase
        end
      end
      default: mem_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ls_exec_unit.sv
// Self-checking bench for ls_exec_unit: directed scenarios plus randomized ops checked
// against a byte-addressed memory model and arithmetic sign/zero extension.
`timescale 1ns/1ps
module tb_ls_exec_unit;
  localparam logic [5:0] OP_LB = 1, OP_LH = 2, OP_LW = 3, OP_LBU = 4, OP_LHU = 5;
  localparam logic [5:0] OP_SB = 6, OP_SH = 7, OP_SW = 8;

  logic        clk = 0;
  logic        rst = 1;
  logic        ena_from_lsb = 0;
  logic [5:0]  openum_from_lsb = 0;
  logic [31:0] mem_addr_from_lsb = 0;
  logic [31:0] store_value_from_lsb = 0;
  logic [3:0]  rob_id_from_lsb = 0;
  logic        busy_to_lsb;
  logic        jump_flag_from_rob = 0;
  logic        mem_req, mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 0;
  logic        mem_grant = 0;
  logic        valid_to_cdb;
  logic [3:0]  rob_id_to_cdb;
  logic [31:0] result_to_cdb;

  ls_exec_unit #(.ROB_W(4), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .ena_from_lsb(ena_from_lsb), .openum_from_lsb(openum_from_lsb),
    .mem_addr_from_lsb(mem_addr_from_lsb), .store_value_from_lsb(store_value_from_lsb),
    .rob_id_from_lsb(rob_id_from_lsb), .busy_to_lsb(busy_to_lsb),
    .jump_flag_from_rob(jump_flag_from_rob), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din), .mem_grant(mem_grant),
    .valid_to_cdb(valid_to_cdb), .rob_id_to_cdb(rob_id_to_cdb), .result_to_cdb(result_to_cdb)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails = 0;
  int cyc = 0;
  int grant_mode = 0;
  logic [7:0] din_next = 0;

  typedef struct { int c; logic [31:0] a; logic wr; logic [7:0] d; } iss_t;
  typedef struct { int c; logic [3:0] rob; logic [31:0] res; } cdb_t;
  iss_t iss_q[$];
  cdb_t cdb_q[$];
  logic [7:0] mem_m [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic int op_size(input logic [5:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic bit op_is_store(input logic [5:0] op);
    return (op == OP_SB || op == OP_SH || op == OP_SW);
  endfunction

  function automatic logic [31:0] load_model(input logic [5:0] op, input logic [31:0] w);
    int unsigned b, h;
    b = w % 256;
    h = w % 65536;
    case (op)
      OP_LB:   return (b >= 128) ? b - 256 : b;
      OP_LH:   return (h >= 32768) ? h - 65536 : h;
      OP_LBU:  return b;
      OP_LHU:  return h;
      default: return w;
    endcase
  endfunction

  // Bus monitor: logs granted byte transfers and CDB pulses, and serves read data.
  initial forever begin
    @(negedge clk);
    if (mem_req && mem_grant) begin
      iss_q.push_back('{c: cyc, a: mem_a, wr: mem_wr, d: mem_dout});
      if (!mem_wr) din_next = rd(mem_a);
    end
    if (valid_to_cdb) cdb_q.push_back('{c: cyc, rob: rob_id_to_cdb, res: result_to_cdb});
  end

  // Memory/arbiter responder: read data one cycle after its grant, grant per mode.
  initial forever begin
    @(posedge clk); #1;
    mem_din = din_next;
    case (grant_mode)
      0:       mem_grant = 1'b1;
      1:       mem_grant = !mem_grant;
      default: mem_grant = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] rob, input int flush_at);
    int n, ena_c, idle_c, t, lim;
    bit st, done, flushed, fl_prev, stall_prev;
    logic [7:0] eb[4];
    logic [31:0] w, er, a_prev;
    n = op_size(op);
    st = op_is_store(op);
    w = 0;
    for (int i = 0; i < 4; i++) begin
      eb[i] = (i < n) ? (st ? data[8*i +: 8] : rd(addr + 32'(i))) : 8'h00;
      w = w | (32'(eb[i]) << (8*i));
    end
    er = load_model(op, w);
    iss_q.delete();
    cdb_q.delete();
    @(posedge clk); #1;
    ena_c = cyc;
    ena_from_lsb = 1; openum_from_lsb = op; mem_addr_from_lsb = addr;
    store_value_from_lsb = data; rob_id_from_lsb = rob; jump_flag_from_rob = (flush_at == 0);
    flushed = (flush_at == 0); done = 0; fl_prev = 0; stall_prev = 0; a_prev = 0; idle_c = -1;
    for (t = 0; t < 300 && !done; t++) begin
      @(posedge clk); #1;
      ena_from_lsb = 0;
      jump_flag_from_rob = !flushed && flush_at > 0 && iss_q.size() >= flush_at;
      if (jump_flag_from_rob) flushed = 1;
      @(negedge clk); #1;
      if (stall_prev && !(fl_prev && !st)) begin
        asserts++;
        if (mem_req !== 1'b1 || mem_a !== a_prev) begin
          fails++;
          $display("FAIL stall_hold: got req=%b a=%08h required req=1 a=%08h", mem_req, mem_a, a_prev);
        end
      end
      if (fl_prev && !st) begin
        asserts++;
        if (mem_req !== 1'b0) begin
          fails++;
          $display("FAIL flush_req_drop: got mem_req=%b required 0", mem_req);
        end
      end
      fl_prev = jump_flag_from_rob;
      stall_prev = mem_req && !mem_grant;
      a_prev = mem_a;
      if (!busy_to_lsb) begin done = 1; idle_c = cyc; end
    end
    jump_flag_from_rob = 0;
    asserts++;
    if (!done) begin fails++; $display("FAIL op_timeout: unit still busy after %0d cycles", t); end
    $display("txn op=%0d addr=%08h data=%08h rob=%0d flush_at=%0d gmode=%0d issued=%0d cdb=%0d",
             op, addr, data, rob, flush_at, grant_mode, iss_q.size(), cdb_q.size());
    if (st) begin
      asserts++;
      if (iss_q.size() != n) begin fails++; $display("FAIL store_bytes: got %0d required %0d", iss_q.size(), n); end
      lim = (iss_q.size() < n) ? iss_q.size() : n;
      for (int i = 0; i < lim; i++) begin
        asserts++;
        if (iss_q[i].a !== addr + 32'(i) || iss_q[i].wr !== 1'b1 || iss_q[i].d !== eb[i]) begin
          fails++;
          $display("FAIL store_write%0d: got a=%08h wr=%b d=%02h required a=%08h wr=1 d=%02h",
                   i, iss_q[i].a, iss_q[i].wr, iss_q[i].d, addr + 32'(i), eb[i]);
        end
      end
      asserts++;
      if (cdb_q.size() != 0) begin fails++; $display("FAIL store_no_cdb: got %0d pulses required 0", cdb_q.size()); end
      if (grant_mode == 0) begin
        asserts++;
        if (idle_c != ena_c + n + 1) begin fails++; $display("FAIL store_latency: got %0d required %0d", idle_c - ena_c, n + 1); end
      end
      for (int i = 0; i < n; i++) mem_m[addr + 32'(i)] = eb[i];
    end else if (flushed) begin
      asserts++;
      if (cdb_q.size() != 0) begin fails++; $display("FAIL flush_no_cdb: got %0d pulses required 0", cdb_q.size()); end
      if (flush_at == 0) begin
        asserts++;
        if (iss_q.size() != 0) begin fails++; $display("FAIL flush_drop: got %0d bytes issued required 0", iss_q.size()); end
      end
    end else begin
      asserts++;
      if (iss_q.size() != n) begin fails++; $display("FAIL load_bytes: got %0d required %0d", iss_q.size(), n); end
      lim = (iss_q.size() < n) ? iss_q.size() : n;
      for (int i = 0; i < lim; i++) begin
        asserts++;
        if (iss_q[i].a !== addr + 32'(i) || iss_q[i].wr !== 1'b0) begin
          fails++;
          $display("FAIL load_read%0d: got a=%08h wr=%b required a=%08h wr=0", i, iss_q[i].a, iss_q[i].wr, addr + 32'(i));
        end
      end
      asserts++;
      if (cdb_q.size() != 1) begin
        fails++;
        $display("FAIL load_pulses: got %0d required 1", cdb_q.size());
      end else begin
        asserts++;
        if (cdb_q[0].rob !== rob || cdb_q[0].res !== er) begin
          fails++;
          $display("FAIL load_result: got rob=%0d res=%08h required rob=%0d res=%08h", cdb_q[0].rob, cdb_q[0].res, rob, er);
        end
        if (grant_mode == 0) begin
          asserts++;
          if (cdb_q[0].c != ena_c + n + 2 || idle_c != ena_c + n + 3) begin
            fails++;
            $display("FAIL load_latency: got done=%0d idle=%0d required done=%0d idle=%0d",
                     cdb_q[0].c - ena_c, idle_c - ena_c, n + 2, n + 3);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    #1 rst = 0;
    #1;
    asserts++;
    if ({mem_req, mem_wr, mem_a, mem_dout, valid_to_cdb, rob_id_to_cdb, result_to_cdb, busy_to_lsb} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b wr=%b a=%08h dout=%02h v=%b rob=%0d res=%08h busy=%b required all 0",
               mem_req, mem_wr, mem_a, mem_dout, valid_to_cdb, rob_id_to_cdb, result_to_cdb, busy_to_lsb);
    end
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_load_word;
    grant_mode = 0;
    mem_m[32'h1000] = 8'h11; mem_m[32'h1001] = 8'h22; mem_m[32'h1002] = 8'h33; mem_m[32'h1003] = 8'h44;
    run_op(OP_LW, 32'h1000, 32'h0, 4'd5, -1);
    for (int i = 1; i < iss_q.size(); i++) begin
      asserts++;
      if (iss_q[i].c != iss_q[0].c + i) begin fails++; $display("FAIL lw_consecutive%0d: got cycle %0d required %0d", i, iss_q[i].c, iss_q[0].c + i); end
    end
    if (cdb_q.size() > 0) begin
      asserts++;
      if (cdb_q[0].res !== 32'h44332211) begin fails++; $display("FAIL lw_value: got %08h required 44332211", cdb_q[0].res); end
    end
  endtask

  task automatic test_load_ext;
    grant_mode = 0;
    mem_m[32'h20] = 8'h80;
    mem_m[32'h30] = 8'h01; mem_m[32'h31] = 8'h80;
    run_op(OP_LB, 32'h20, 32'h0, 4'd1, -1);
    if (cdb_q.size() > 0) begin
      asserts++;
      if (cdb_q[0].res !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_sign: got %08h required ffffff80", cdb_q[0].res); end
    end
    run_op(OP_LBU, 32'h20, 32'h0, 4'd2, -1);
    if (cdb_q.size() > 0) begin
      asserts++;
      if (cdb_q[0].res !== 32'h00000080) begin fails++; $display("FAIL lbu_zero: got %08h required 00000080", cdb_q[0].res); end
    end
    run_op(OP_LHU, 32'h30, 32'h0, 4'd3, -1);
    if (cdb_q.size() > 0) begin
      asserts++;
      if (cdb_q[0].res !== 32'h00008001) begin fails++; $display("FAIL lhu_zero: got %08h required 00008001", cdb_q[0].res); end
    end
    run_op(OP_LH, 32'h30, 32'h0, 4'd4, -1);
  endtask

  task automatic test_store_stall;
    grant_mode = 1;
    run_op(OP_SW, 32'h100, 32'hDEADBEEF, 4'd6, -1);
    grant_mode = 0;
    run_op(OP_LW, 32'h100, 32'h0, 4'd7, -1);
  endtask

  task automatic test_load_flush;
    grant_mode = 0;
    run_op(OP_LW, 32'h3000, 32'h0, 4'd8, 2);
    run_op(OP_LW, 32'h3000, 32'h0, 4'd9, -1);
  endtask

  task automatic test_store_flush;
    grant_mode = 0;
    run_op(OP_SH, 32'h500, 32'h0000A5C3, 4'd10, 1);
    run_op(OP_LHU, 32'h500, 32'h0, 4'd11, -1);
  endtask

  task automatic test_back_to_back;
    int c0;
    grant_mode = 0;
    mem_m[32'h40] = 8'h7F; mem_m[32'h41] = 8'h9C;
    iss_q.delete(); cdb_q.delete();
    @(posedge clk); #1;
    c0 = cyc;
    ena_from_lsb = 1; openum_from_lsb = OP_LB; mem_addr_from_lsb = 32'h40; rob_id_from_lsb = 4'd5;
    @(posedge clk); #1;  // request while busy must be ignored
    openum_from_lsb = OP_LBU; mem_addr_from_lsb = 32'h41; rob_id_from_lsb = 4'd6;
    @(posedge clk); #1;
    ena_from_lsb = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ena_from_lsb = 1; openum_from_lsb = OP_LBU; mem_addr_from_lsb = 32'h41; rob_id_from_lsb = 4'd7;
    @(posedge clk); #1;
    ena_from_lsb = 0;
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    $display("txn back_to_back LB rob=5 then LBU rob=7 at +4 cycles, cdb=%0d", cdb_q.size());
    asserts++;
    if (cdb_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_pulses: got %0d required 2", cdb_q.size());
    end else begin
      asserts++;
      if (cdb_q[0].rob !== 4'd5 || cdb_q[0].res !== 32'h0000007F || cdb_q[0].c != c0 + 3) begin
        fails++;
        $display("FAIL b2b_first: got rob=%0d res=%08h at +%0d required rob=5 res=0000007f at +3", cdb_q[0].rob, cdb_q[0].res, cdb_q[0].c - c0);
      end
      asserts++;
      if (cdb_q[1].rob !== 4'd7 || cdb_q[1].res !== 32'h0000009C || cdb_q[1].c != c0 + 7) begin
        fails++;
        $display("FAIL b2b_second: got rob=%0d res=%08h at +%0d required rob=7 res=0000009c at +7", cdb_q[1].rob, cdb_q[1].res, cdb_q[1].c - c0);
      end
    end
  endtask

  task automatic test_async_reset;
    grant_mode = 0;
    @(posedge clk); #1;
    ena_from_lsb = 1; openum_from_lsb = OP_LW; mem_addr_from_lsb = 32'h2000; rob_id_from_lsb = 4'd9;
    @(posedge clk); #1;
    ena_from_lsb = 0;
    @(posedge clk); #3;
    rst = 0;
    #1;
    asserts++;
    if ({mem_req, mem_wr, mem_a, valid_to_cdb, busy_to_lsb} !== '0) begin
      fails++;
      $display("FAIL async_reset: got req=%b wr=%b a=%08h v=%b busy=%b required all 0", mem_req, mem_wr, mem_a, valid_to_cdb, busy_to_lsb);
    end
    @(negedge clk); #2;
    rst = 1;
    iss_q.delete(); cdb_q.delete();
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    $display("txn async reset during LW rob=9, after release issued=%0d cdb=%0d", iss_q.size(), cdb_q.size());
    asserts++;
    if (iss_q.size() != 0 || cdb_q.size() != 0) begin
      fails++;
      $display("FAIL reset_abandon: got issued=%0d cdb=%0d required 0 and 0", iss_q.size(), cdb_q.size());
    end
  endtask

  task automatic test_random;
    logic [5:0] op;
    logic [31:0] addr;
    int fl;
    for (int k = 0; k < 40; k++) begin
      op = 6'($urandom_range(1, 8));
      case ($urandom_range(0, 3))
        0:       addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        1:       addr = 32'($urandom_range(0, 255));
        default: addr = $urandom;
      endcase
      grant_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, op_size(op))) : -1;
      run_op(op, addr, $urandom, 4'($urandom_range(1, 15)), fl);
    end
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_load_ext;
    test_store_stall;
    test_load_flush;
    test_store_flush;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
